xor_parity_frame_rx: RTL and testbench
======================================

# xor_parity_frame_rx

Serial frame receiver and parity checker: the consuming end of the XOR parity path our 74x86-based generators drive. Accepts a qualified serial bit stream of WIDTH data bits (LSB first) followed by one parity bit. Reassembles the word, recomputes parity with a running XOR, flags mismatches and keeps a saturating error count. Sits between the serial link input and the parallel data bus of the glue-logic datapath.

## Interface
- WIDTH, 8, data bits per frame (2..32)
- CNT_WIDTH, 8, width of the parity-error counter
- CLK  in  1  rising-edge clock; single clock domain
- RST  in  1  synchronous, active-high reset
- SIN  in  1  serial data bit
- SVALID  in  1  SIN valid this cycle; bits are consumed only when high
- SSYNC  in  1  frame-start marker; meaningful only with SVALID=1, marks SIN as data bit 0
- Q  out  WIDTH  last completed data word
- QVALID  out  1  one-cycle pulse: Q/PERR updated
- PERR  out  1  parity mismatch for the word on Q
- BUSY  out  1  frame in progress (state DATA or PAR)
- ERRCNT  out  CNT_WIDTH  saturating count of frames with PERR=1

## Operation
- States: IDLE, DATA, PAR. Bit counter BITCNT (0..WIDTH-1), shift register SR, running parity P.
- IDLE: SVALID&SSYNC -> SR[0]=SIN, P=SIN, BITCNT=1, go DATA (WIDTH>=2 guaranteed). SVALID without SSYNC: bit discarded, stay IDLE.
- DATA: each SVALID cycle stores SIN at SR[BITCNT], P^=SIN, BITCNT++. After bit WIDTH-1 stored -> PAR.
- PAR: on SVALID, parity bit SIN compared: expected = P (even parity) or ~P (odd parity, see Configuration). Q<=SR, PERR<=(SIN!=expected), QVALID pulse, ERRCNT increments if mismatch. Go IDLE.
- SVALID=0 in any state: hold everything; no timeout.
- SSYNC with SVALID in DATA or PAR: current frame aborted silently (no QVALID, no ERRCNT change); the bit is taken as bit 0 of a new frame (same as IDLE entry).
- SSYNC is ignored when SVALID=0.
- ERRCNT saturates at all-ones; never wraps.
- Q and PERR hold their values between frames; only QVALID pulses.

## Timing
- Reset values: Q=0, QVALID=0, PERR=0, BUSY=0, ERRCNT=0, state IDLE, BITCNT=0, SR=0, P=0.
- RST has priority over all inputs in the same cycle; reset mid-frame discards the partial frame, no QVALID.
- Latency: parity bit accepted at edge N -> Q, PERR, QVALID=1, ERRCNT visible after edge N; QVALID low after edge N+1 unless another frame completes (impossible; minimum frame is WIDTH+1 valid cycles).
- BUSY registered: high from the edge consuming bit 0 until the edge consuming the parity bit.
- Back-to-back frames: SSYNC bit may arrive the cycle after the parity bit; full throughput of one bit per cycle.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- PARITY_ODD_EN defined: odd parity; expected parity bit = ~(XOR of data bits) (data+parity has odd ones count).
- Not defined: even parity; expected parity bit = XOR of data bits.
- No other behaviour changes.

## Test plan
- Reset then WIDTH=8, even build: send 0xA5 LSB first with SSYNC on bit 0, parity 0 -> Q=0xA5, PERR=0, QVALID one cycle, ERRCNT=0.
- Same frame with parity 1 -> Q=0xA5, PERR=1, ERRCNT=1; odd build with parity 1 -> PERR=0, ERRCNT=0.
- 0x3C sent with SVALID deasserted randomly between bits -> Q=0x3C after 9th valid bit, BUSY high throughout, no early QVALID.
- SSYNC after 5 bits of a frame, then full 0xFF frame with parity 0 -> exactly one QVALID, Q=0xFF, PERR=0, aborted frame not counted.
- CNT_WIDTH=2: five consecutive bad-parity frames -> ERRCNT 1,2,3,3,3; RST asserted mid-frame -> all outputs 0, next clean frame decoded correctly.
- Back-to-back frames 0x01, 0x80, zero idle cycles -> two QVALID pulses 9 cycles apart, Q values in order.

Source files
------------

// File: rtl/xor_parity_frame_rx.sv
// Serial frame receiver: WIDTH data bits LSB first plus one parity bit, running-XOR check,
// saturating error count. Define PARITY_ODD_EN for odd parity (default build: even parity).
module xor_parity_frame_rx #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 sin_i,
   input  logic                 svalid_i,
   input  logic                 ssync_i,
   output logic [WIDTH-1:0]     q_o,
   output logic                 qvalid_o,
   output logic                 perr_o,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] errcnt_o
);

   localparam int unsigned BcW = $clog2(WIDTH);
   localparam logic [BcW-1:0] LastBit = BcW'(WIDTH - 1);

`ifdef PARITY_ODD_EN
   localparam logic OddPar = 1'b1;
`else
   localparam logic OddPar = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

   state_e               state_q, state_d;
   logic [BcW-1:0]       bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0]     sr_q, sr_d;
   logic                 par_q, par_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 qvalid_q, qvalid_d;
   logic                 perr_q, perr_d;
   logic                 busy_q, busy_d;
   logic [CNT_WIDTH-1:0] errcnt_q, errcnt_d;
   logic                 mismatch;

   assign mismatch = sin_i ^ par_q ^ OddPar;

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      sr_d     = sr_q;
      par_d    = par_q;
      q_d      = q_q;
      qvalid_d = 1'b0;
      perr_d   = perr_q;
      errcnt_d = errcnt_q;
      if (svalid_i) begin
         if (ssync_i) begin
            // A sync bit always starts a fresh frame; any partial frame is dropped silently.
            sr_d     = '0;
            sr_d[0]  = sin_i;
            par_d    = sin_i;
            bitcnt_d = BcW'(1);
            state_d  = StData;
         end else begin
            unique case (state_q)
               StIdle: ;
               StData: begin
                  sr_d[bitcnt_q] = sin_i;
                  par_d          = par_q ^ sin_i;
                  if (bitcnt_q == LastBit) begin
                     bitcnt_d = '0;
                     state_d  = StPar;
                  end else begin
                     bitcnt_d = bitcnt_q + BcW'(1);
                  end
               end
               StPar: begin
                  q_d      = sr_q;
                  perr_d   = mismatch;
                  qvalid_d = 1'b1;
                  if (mismatch && (errcnt_q != '1)) begin
                     errcnt_d = errcnt_q + CNT_WIDTH'(1);
                  end
                  state_d = StIdle;
               end
               default: state_d = StIdle;
            endcase
         end
      end
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         bitcnt_q <= '0;
         sr_q     <= '0;
         par_q    <= 1'b0;
         q_q      <= '0;
         qvalid_q <= 1'b0;
         perr_q   <= 1'b0;
         busy_q   <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         sr_q     <= sr_d;
         par_q    <= par_d;
         q_q      <= q_d;
         qvalid_q <= qvalid_d;
         perr_q   <= perr_d;
         busy_q   <= busy_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign q_o      = q_q;
   assign qvalid_o = qvalid_q;
   assign perr_o   = perr_q;
   assign busy_o   = busy_q;
   assign errcnt_o = errcnt_q;

endmodule

// File: tb/tb_xor_parity_frame_rx.sv
// Scoreboard bench for xor_parity_frame_rx (WIDTH=8, CNT_WIDTH=2); expectations follow
// PARITY_ODD_EN when that macro is defined.
module tb_xor_parity_frame_rx;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 2;
`ifdef PARITY_ODD_EN
   localparam bit Odd = 1'b1;
`else
   localparam bit Odd = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0]  q;
      logic          perr;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, sin, svalid, ssync;
   logic [W-1:0]  q;
   logic          qvalid, perr, busy;
   logic [CW-1:0] errcnt;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   exp_t sb_q[$];
   int   pulse_q[$];
   logic [CW-1:0] model_cnt = '0;

   xor_parity_frame_rx #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .sin_i   (sin),
      .svalid_i(svalid),
      .ssync_i (ssync),
      .q_o     (q),
      .qvalid_o(qvalid),
      .perr_o  (perr),
      .busy_o  (busy),
      .errcnt_o(errcnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every QVALID pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (qvalid === 1'b1) begin
         exp_t e;
         pulse_q.push_back(cyc);
         if (sb_q.size() == 0) begin
            chk("unexpected_qvalid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("perr", 32'(perr), 32'(e.perr));
            chk("errcnt", 32'(errcnt), 32'(e.cnt));
         end
      end
   end

   task automatic drive(input logic v, input logic s, input logic d);
      svalid = v;
      ssync  = s;
      sin    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      model_cnt = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_q"}, 32'(q), 32'd0);
      chk({tag, "_qvalid"}, 32'(qvalid), 32'd0);
      chk({tag, "_perr"}, 32'(perr), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_errcnt"}, 32'(errcnt), 32'd0);
   endtask

   // exp_perr is hand-supplied per frame; the bench flips it for the odd-parity build.
   task automatic send_frame(input logic [W-1:0] data, input logic parity,
                             input logic exp_perr_even, input bit gaps);
      exp_t e;
      logic ep;
      ep = exp_perr_even ^ Odd;
      for (int i = 0; i < W; i++) begin
         drive(1'b1, (i == 0), data[i]);
         if (gaps) chk("busy_data", 32'(busy), 32'd1);
         if (gaps && (i % 2 == 1)) begin
            idle(1 + i / 3);
            chk("busy_gap", 32'(busy), 32'd1);
         end
      end
      if (ep && model_cnt != '1) model_cnt = model_cnt + 1'b1;
      e.q    = data;
      e.perr = ep;
      e.cnt  = model_cnt;
      sb_q.push_back(e);
      drive(1'b1, 1'b0, parity);
      if (gaps) chk("busy_after_par", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b0; sin = 1'b0; svalid = 1'b0; ssync = 1'b0;
      do_reset();
      check_zero("reset");

      // 0xA5 has four ones: parity 0 is good, parity 1 is bad.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      idle(2);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      idle(2);

      // 0x3C with idle gaps between bits.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Abort after 5 bits, then a full 0xFF frame.
      for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), 1'b1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
      idle(2);

      // Saturation of the 2-bit counter: 0x00 with parity 1 is bad (even build).
      do_reset();
      for (int k = 0; k < 5; k++) begin
         send_frame(8'h00, 1'b1, 1'b1, 1'b0);
         idle(1);
      end
      idle(2);

      // Reset mid-frame, then a clean frame.
      for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 1'b1);
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b1);
      rst = 1'b0;
      model_cnt = '0;
      check_zero("midreset");
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      idle(2);

      // Back-to-back frames, zero idle cycles.
      pulse_q.delete();
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      send_frame(8'h80, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("b2b_pulses", 32'(pulse_q.size()), 32'd2);
      if (pulse_q.size() == 2) chk("b2b_spacing", 32'(pulse_q[1] - pulse_q[0]), 32'd9);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
